// File: rtl/mipi_csi2_pkt_parser.sv
// CSI-2 low-level packet parser: header decode, sync pulses, payload byte stream, boundary checks.
// Optional payload CRC-16 check is enabled by defining MIPI_CRC_CHECK_EN.
module mipi_csi2_pkt_parser #(
    parameter logic [15:0] MAX_WC = 16'd8192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_in,
    input  logic [7:0]  data_in,
    output logic        hdr_valid,
    output logic [1:0]  hdr_vc,
    output logic [5:0]  hdr_dt,
    output logic [15:0] hdr_wc,
    output logic        frame_start,
    output logic        frame_end,
    output logic        line_start,
    output logic        line_end,
    output logic        pix_we,
    output logic [7:0]  pix_data,
    output logic [5:0]  pix_dt,
    output logic        hdr_err,
    output logic        trunc_err,
    output logic        crc_err,
    output logic [15:0] pkt_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_CRC,
        S_DRAIN
    } state_t;

    state_t      r_state;
    logic [1:0]  r_hdr_cnt;
    logic [7:0]  r_di;
    logic [7:0]  r_wc_ls;
    logic [7:0]  r_wc_ms;
    logic [15:0] r_rem;
    logic        r_crc_cnt;

    logic [15:0] w_wc;
    logic [5:0]  w_dt;
    logic        w_short;
    logic        w_too_big;
    logic        w_hdr_done;

    assign w_wc       = {r_wc_ms, r_wc_ls};
    assign w_dt       = r_di[5:0];
    assign w_short    = (w_dt[5:4] == 2'b00);
    assign w_too_big  = (w_wc > MAX_WC);
    assign w_hdr_done = (r_state == S_HDR) && we_in && (r_hdr_cnt == 2'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hdr_cnt   <= 2'd0;
            r_di        <= 8'h00;
            r_wc_ls     <= 8'h00;
            r_wc_ms     <= 8'h00;
            r_rem       <= 16'h0000;
            r_crc_cnt   <= 1'b0;
            hdr_valid   <= 1'b0;
            hdr_vc      <= 2'd0;
            hdr_dt      <= 6'd0;
            hdr_wc      <= 16'h0000;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            pix_we      <= 1'b0;
            pix_data    <= 8'h00;
            pix_dt      <= 6'd0;
            hdr_err     <= 1'b0;
            trunc_err   <= 1'b0;
            pkt_count   <= 16'h0000;
        end else begin
            // NOTE: pulse outputs default low every cycle so each branch only raises what it fires.
            hdr_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            pix_we      <= 1'b0;
            hdr_err     <= 1'b0;
            trunc_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (we_in) begin
                        r_di      <= data_in;
                        r_hdr_cnt <= 2'd0;
                        r_state   <= S_HDR;
                    end
                end

                S_HDR: begin
                    if (!we_in) begin
                        trunc_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_hdr_cnt <= r_hdr_cnt + 2'd1;
                        if (r_hdr_cnt == 2'd0) r_wc_ls <= data_in;
                        if (r_hdr_cnt == 2'd1) r_wc_ms <= data_in;
                        if (w_hdr_done) begin
                            // ECC byte is consumed without checking or correction.
                            hdr_valid <= 1'b1;
                            hdr_vc    <= r_di[7:6];
                            hdr_dt    <= w_dt;
                            hdr_wc    <= w_wc;
                            pix_dt    <= w_dt;
                            pkt_count <= pkt_count + 16'd1;
                            r_crc_cnt <= 1'b0;
                            if (w_short) begin
                                frame_start <= (w_dt == 6'h00);
                                frame_end   <= (w_dt == 6'h01);
                                line_start  <= (w_dt == 6'h02);
                                line_end    <= (w_dt == 6'h03);
                                r_state     <= S_DRAIN;
                            end else if (w_too_big) begin
                                hdr_err <= 1'b1;
                                r_state <= S_DRAIN;
                            end else if (w_wc == 16'h0000) begin
                                r_state <= S_CRC;
                            end else begin
                                r_rem   <= w_wc;
                                r_state <= S_PAYLOAD;
                            end
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (!we_in) begin
                        trunc_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        pix_we   <= 1'b1;
                        pix_data <= data_in;
                        r_rem    <= r_rem - 16'd1;
                        if (r_rem == 16'd1) begin
                            r_crc_cnt <= 1'b0;
                            r_state   <= S_CRC;
                        end
                    end
                end

                S_CRC: begin
                    if (!we_in) begin
                        trunc_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_crc_cnt <= 1'b1;
                        if (r_crc_cnt) r_state <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    // Trailer/padding bytes are swallowed; a new packet needs a new burst.
                    if (!we_in) r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MIPI_CRC_CHECK_EN
    logic [15:0] r_crc;
    logic [7:0]  r_crc_ls;
    logic [15:0] w_crc_next;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            x = x[0] ? ((x >> 1) ^ 16'h8408) : (x >> 1);
        end
        return x;
    endfunction

    assign w_crc_next = crc16_byte(r_crc, data_in);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crc    <= 16'hFFFF;
            r_crc_ls <= 8'h00;
            crc_err  <= 1'b0;
        end else begin
            crc_err <= 1'b0;
            if (w_hdr_done) begin
                r_crc <= 16'hFFFF;
            end else if (r_state == S_PAYLOAD && we_in) begin
                r_crc <= w_crc_next;
            end else if (r_state == S_CRC && we_in) begin
                if (!r_crc_cnt) r_crc_ls <= data_in;
                else            crc_err  <= ({data_in, r_crc_ls} != r_crc);
            end
        end
    end
`else
    assign crc_err = 1'b0;
`endif

endmodule
